// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - instruction sequencer for the 16-bit basic CPU (T0..T3 slots)
module cpu_control (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRun,
  input  logic [15:0] iDIN,
  output logic [9:0]  oSel,
  output logic [7:0]  oRin,
  output logic        oAin,
  output logic        oGin,
  output logic        oAddSub,
  output logic        oDone,
  output logic [8:0]  oIR
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // bus select positions above the eight general registers
  localparam logic [9:0] SEL_G   = 10'h100;
  localparam logic [9:0] SEL_DIN = 10'h200;

  state_t      state;
  state_t      state_next;
  logic [8:0]  ir;
  logic [8:0]  ir_next;

  logic [2:0]  op;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [7:0]  rx_hot;
  logic [7:0]  ry_hot;

  // decoded (pre-reset-gating) control values
  logic [9:0]  sel_dec;
  logic [7:0]  rin_dec;
  logic        ain_dec;
  logic        gin_dec;
  logic        addsub_dec;
  logic        done_dec;

  assign op     = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];
  assign rx_hot = 8'b0000_0001 << rx;
  assign ry_hot = 8'b0000_0001 << ry;

  // state and instruction register; reset aborts any instruction in flight
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= T0;
      ir    <= 9'h000;
    end else begin
      state <= state_next;
      ir    <= ir_next;
    end
  end

  // next-state and per-slot control decode
  always_comb begin
    state_next = state;
    ir_next    = ir;
    sel_dec    = 10'h000;
    rin_dec    = 8'h00;
    ain_dec    = 1'b0;
    gin_dec    = 1'b0;
    addsub_dec = 1'b0;
    done_dec   = 1'b0;

    case (state)
      T0: begin
        // fetch: only the upper nine bits carry opcode and register fields
        if (iRun) begin
          ir_next    = iDIN[15:7];
          state_next = T1;
        end
      end

      T1: begin
        case (op)
          OP_MV: begin
            sel_dec    = {2'b00, ry_hot};
            rin_dec    = rx_hot;
            done_dec   = 1'b1;
            state_next = T0;
          end
          OP_MVI: begin
            sel_dec    = SEL_DIN;
            rin_dec    = rx_hot;
            done_dec   = 1'b1;
            state_next = T0;
          end
          OP_ADD, OP_SUB: begin
            sel_dec    = {2'b00, rx_hot};
            ain_dec    = 1'b1;
            state_next = T2;
          end
          default: begin
            // undefined opcodes retire as a no-op
            done_dec   = 1'b1;
            state_next = T0;
          end
        endcase
      end

      T2: begin
        sel_dec    = {2'b00, ry_hot};
        gin_dec    = 1'b1;
        addsub_dec = op[0];
        state_next = T3;
      end

      T3: begin
        sel_dec    = SEL_G;
        rin_dec    = rx_hot;
        done_dec   = 1'b1;
        state_next = T0;
      end

      default: begin
        state_next = T0;
      end
    endcase
  end

  // reset overrides the decode in the same cycle so no enable escapes
  always_comb begin
    oSel    = 10'h000;
    oRin    = 8'h00;
    oAin    = 1'b0;
    oGin    = 1'b0;
    oAddSub = 1'b0;
    oDone   = 1'b0;
    oIR     = 9'h000;
    if (!iRst) begin
      oSel    = sel_dec;
      oRin    = rin_dec;
      oAin    = ain_dec;
      oGin    = gin_dec;
      oAddSub = addsub_dec;
      oDone   = done_dec;
      oIR     = ir;
    end
  end

endmodule
